fetch_pc_unit: RTL and testbench

//  Parametrised fetch-address generator: owns the PC, issues requests on a req/addr_ok/data_ok

---
 rtl/fetch_pc_unit_if.sv | 31 +++
 rtl/fetch_pc_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_pc_unit.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_if.sv
// Instruction-bus and decode-delivery signals of the fetch PC unit.
// master = fetch unit side, slave = memory/decode side.
interface fetch_pc_unit_if #(
  parameter int ADDR_W      = 32,
  parameter int FETCH_BYTES = 4
);
  logic                     inst_req_o;
  logic [ADDR_W-1:0]        inst_addr_o;
  logic                     inst_addr_ok_i;
  logic                     inst_data_ok_i;
  logic [FETCH_BYTES*8-1:0] inst_rdata_i;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic [ADDR_W-1:0]        out_pc_o;
  logic [FETCH_BYTES*8-1:0] out_inst_o;
  logic                     out_adel_o;

  modport master (
    output inst_req_o, inst_addr_o,
    input  inst_addr_ok_i, inst_data_ok_i, inst_rdata_i,
    output out_valid_o, out_pc_o, out_inst_o, out_adel_o,
    input  out_ready_i
  );

  modport slave (
    input  inst_req_o, inst_addr_o,
    output inst_addr_ok_i, inst_data_ok_i, inst_rdata_i,
    input  out_valid_o, out_pc_o, out_inst_o, out_adel_o,
    output out_ready_i
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch PC generator with an in-order queue of outstanding fetches; stale responses are dropped.
// Optional FETCH_DISCARD_CNT_EN adds discard_cnt_o counting killed entries popped.
module fetch_pc_unit #(
  parameter int                ADDR_W          = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR    = ADDR_W'(32'hbfc0_0000),
  parameter int                FETCH_BYTES     = 4,
  parameter int                MAX_OUTSTANDING = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exception,
  input  logic [ADDR_W-1:0]  exception_pc_i,
  input  logic               branch_enable_i,
  input  logic [ADDR_W-1:0]  branch_addr_i,
  output logic [ADDR_W-1:0]  pc_o,
`ifdef FETCH_DISCARD_CNT_EN
  output logic [31:0]        discard_cnt_o,
`endif
  fetch_pc_unit_if.master    bus
);

  localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DATA_W = FETCH_BYTES * 8;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(MAX_OUTSTANDING);

  logic [ADDR_W-1:0]          ent_pc_q   [MAX_OUTSTANDING];
  logic [DATA_W-1:0]          ent_inst_q [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] ent_filled_q;
  logic [MAX_OUTSTANDING-1:0] ent_kill_q;
  logic [MAX_OUTSTANDING-1:0] ent_adel_q;
  logic [PTR_W-1:0]           head_q;
  logic [PTR_W-1:0]           tail_q;
  logic [CNT_W-1:0]           count_q;
  logic [ADDR_W-1:0]          pc_q;
  logic                       misal_done_q;
`ifdef FETCH_DISCARD_CNT_EN
  logic [31:0]                discard_cnt_q;
`endif

  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic              misaligned;
  logic              full;
  logic              req;
  logic              handshake;
  logic              mis_alloc;
  logic              alloc;
  logic              head_live;
  logic              head_filled;
  logic              head_kill;
  logic              out_valid;
  logic              pop;
  logic              fill_hit;
  logic [PTR_W-1:0]  fill_idx;
  logic [PTR_W-1:0]  idx_k;
  logic              fill;

  assign redirect    = exception | branch_enable_i;
  assign target      = exception ? exception_pc_i : branch_addr_i;
  assign misaligned  = pc_q[1:0] != 2'b00;
  assign full        = count_q == DEPTH;
  // Gated by rst so the request drops the instant reset asserts.
  assign req         = rst & ~misaligned & ~full;
  assign handshake   = req & bus.inst_addr_ok_i;
  assign mis_alloc   = misaligned & ~full & ~misal_done_q;
  assign alloc       = handshake | mis_alloc;
  assign head_live   = count_q != '0;
  assign head_filled = ent_filled_q[head_q];
  assign head_kill   = ent_kill_q[head_q];
  assign out_valid   = head_live & head_filled & ~head_kill & ~redirect;
  assign pop         = head_live & head_filled & (head_kill | (out_valid & bus.out_ready_i));

  // Misaligned entries are born filled, so the oldest unfilled entry need not sit at head.
  always_comb begin
    fill_hit = 1'b0;
    fill_idx = '0;
    idx_k    = '0;
    for (int unsigned k = 0; k < MAX_OUTSTANDING; k++) begin
      idx_k = head_q + PTR_W'(k);
      if (!fill_hit && (CNT_W'(k) < count_q) && !ent_filled_q[idx_k]) begin
        fill_hit = 1'b1;
        fill_idx = idx_k;
      end
    end
  end

  assign fill = bus.inst_data_ok_i & fill_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        ent_pc_q[i]   <= '0;
        ent_inst_q[i] <= '0;
      end
      ent_filled_q  <= '0;
      ent_kill_q    <= '0;
      ent_adel_q    <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      pc_q          <= RESET_VECTOR;
      misal_done_q  <= 1'b0;
`ifdef FETCH_DISCARD_CNT_EN
      discard_cnt_q <= '0;
`endif
    end else begin
      if (redirect) pc_q <= target;
      else if (handshake) pc_q <= pc_q + ADDR_W'(FETCH_BYTES);

      if (redirect) misal_done_q <= 1'b0;
      else if (mis_alloc) misal_done_q <= 1'b1;

      if (fill) begin
        ent_inst_q[fill_idx]   <= bus.inst_rdata_i;
        ent_filled_q[fill_idx] <= 1'b1;
      end

      // Dead slots get kill too; allocation rewrites kill, so only live entries matter.
      if (redirect) ent_kill_q <= '1;

      if (alloc) begin
        ent_pc_q[tail_q]     <= pc_q;
        ent_inst_q[tail_q]   <= '0;
        ent_filled_q[tail_q] <= mis_alloc;
        ent_adel_q[tail_q]   <= mis_alloc;
        ent_kill_q[tail_q]   <= redirect;
      end

      tail_q  <= tail_q + PTR_W'(alloc);
      head_q  <= head_q + PTR_W'(pop);
      count_q <= count_q + CNT_W'(alloc) - CNT_W'(pop);
`ifdef FETCH_DISCARD_CNT_EN
      if (pop && head_kill) discard_cnt_q <= discard_cnt_q + 32'd1;
`endif
    end
  end

  assign pc_o            = pc_q;
  assign bus.inst_req_o  = req;
  assign bus.inst_addr_o = pc_q;
  assign bus.out_valid_o = out_valid;
  assign bus.out_pc_o    = ent_pc_q[head_q];
  assign bus.out_inst_o  = ent_inst_q[head_q];
  assign bus.out_adel_o  = ent_adel_q[head_q];
`ifdef FETCH_DISCARD_CNT_EN
  assign discard_cnt_o   = discard_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: default build (FB=4, depth 2) and a wide build (FB=8, depth 4)
// run side by side against a queue-level reference model.
module tb_fetch_pc_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        exc_v    [2];
  logic [31:0] exc_pc_v [2];
  logic        br_v     [2];
  logic [31:0] br_addr_v[2];
  logic        aok_v    [2];
  logic        dok_v    [2];
  logic [63:0] rdata_v  [2];
  logic        rdy_v    [2];
  int          pin;

  logic [31:0] pc_v   [2];
  logic        req_v  [2];
  logic [31:0] addr_v [2];
  logic        ov_v   [2];
  logic [31:0] opc_v  [2];
  logic [63:0] oinst_v[2];
  logic        oadel_v[2];
  logic [31:0] dcnt_v [2];

  fetch_pc_unit_if #(.ADDR_W(32), .FETCH_BYTES(4)) bus0 ();
  fetch_pc_unit_if #(.ADDR_W(32), .FETCH_BYTES(8)) bus1 ();

  fetch_pc_unit #(.ADDR_W(32), .FETCH_BYTES(4), .MAX_OUTSTANDING(2)) u0 (
    .clk(clk), .rst(rst),
    .exception(exc_v[0]), .exception_pc_i(exc_pc_v[0]),
    .branch_enable_i(br_v[0]), .branch_addr_i(br_addr_v[0]),
    .pc_o(pc_v[0]),
`ifdef FETCH_DISCARD_CNT_EN
    .discard_cnt_o(dcnt_v[0]),
`endif
    .bus(bus0)
  );

  fetch_pc_unit #(.ADDR_W(32), .FETCH_BYTES(8), .MAX_OUTSTANDING(4)) u1 (
    .clk(clk), .rst(rst),
    .exception(exc_v[1]), .exception_pc_i(exc_pc_v[1]),
    .branch_enable_i(br_v[1]), .branch_addr_i(br_addr_v[1]),
    .pc_o(pc_v[1]),
`ifdef FETCH_DISCARD_CNT_EN
    .discard_cnt_o(dcnt_v[1]),
`endif
    .bus(bus1)
  );

`ifndef FETCH_DISCARD_CNT_EN
  assign dcnt_v[0] = 32'h0;
  assign dcnt_v[1] = 32'h0;
`endif

  assign bus0.inst_addr_ok_i = aok_v[0];
  assign bus0.inst_data_ok_i = dok_v[0];
  assign bus0.inst_rdata_i   = rdata_v[0][31:0];
  assign bus0.out_ready_i    = rdy_v[0];
  assign bus1.inst_addr_ok_i = aok_v[1];
  assign bus1.inst_data_ok_i = dok_v[1];
  assign bus1.inst_rdata_i   = rdata_v[1];
  assign bus1.out_ready_i    = rdy_v[1];

  assign req_v[0]   = bus0.inst_req_o;
  assign addr_v[0]  = bus0.inst_addr_o;
  assign ov_v[0]    = bus0.out_valid_o;
  assign opc_v[0]   = bus0.out_pc_o;
  assign oinst_v[0] = {32'h0, bus0.out_inst_o};
  assign oadel_v[0] = bus0.out_adel_o;
  assign req_v[1]   = bus1.inst_req_o;
  assign addr_v[1]  = bus1.inst_addr_o;
  assign ov_v[1]    = bus1.out_valid_o;
  assign opc_v[1]   = bus1.out_pc_o;
  assign oinst_v[1] = bus1.out_inst_o;
  assign oadel_v[1] = bus1.out_adel_o;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [63:0] inst;
    bit          filled;
    bit          kill;
    bit          adel;
  } ent_t;

  ent_t        mq[2][$];
  logic [31:0] mpc  [2];
  bit          mdone[2];
  logic [31:0] mdisc[2];

  int          checks   = 0;
  int          failures = 0;

  int          hs_tot[2], dl_tot[2], adel_tot[2];
  logic [31:0] hs_addr[2][4];
  logic [31:0] first_dpc[2], last_dpc[2];
  logic [63:0] last_dinst[2];
  bit          last_dadel[2];
  int          hs_snap[2], dl_snap[2], adel_snap[2];
  logic [31:0] pc_snap[2], disc_snap[2], dcnt_snap[2];

  function automatic int unsigned fb(int g);  return (g == 0) ? 4 : 8; endfunction
  function automatic int unsigned mo(int g);  return (g == 0) ? 2 : 4; endfunction
  function automatic logic [63:0] imask(int g);
    return (g == 0) ? 64'h0000_0000_ffff_ffff : 64'hffff_ffff_ffff_ffff;
  endfunction

  function automatic bit has_unf(int g);
    for (int i = 0; i < mq[g].size(); i++) if (!mq[g][i].filled) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%h expected=%h t=%0t", nm, g, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int g);
    mq[g].delete();
    mpc[g]   = 32'hbfc0_0000;
    mdone[g] = 1'b0;
    mdisc[g] = 32'h0;
  endtask

  task automatic model_step(input int g);
    bit          redir, mis, full, e_req, e_ov, hs, malloc, pop, pop_kill, found;
    logic [31:0] tgt;
    ent_t        e;
    redir = exc_v[g] | br_v[g];
    tgt   = exc_v[g] ? exc_pc_v[g] : br_addr_v[g];
    mis   = mpc[g][1:0] != 2'b00;
    full  = mq[g].size() == int'(mo(g));
    e_req = !mis && !full;
    e_ov  = (mq[g].size() > 0) && mq[g][0].filled && !mq[g][0].kill && !redir;

    chk("pc_o", g, 64'(pc_v[g]), 64'(mpc[g]));
    chk("inst_addr_o", g, 64'(addr_v[g]), 64'(mpc[g]));
    chk("inst_req_o", g, 64'(req_v[g]), 64'(e_req));
    chk("out_valid_o", g, 64'(ov_v[g]), 64'(e_ov));
    if (e_ov) begin
      chk("out_pc_o", g, 64'(opc_v[g]), 64'(mq[g][0].pc));
      chk("out_inst_o", g, oinst_v[g], mq[g][0].inst);
      chk("out_adel_o", g, 64'(oadel_v[g]), 64'(mq[g][0].adel));
    end
`ifdef FETCH_DISCARD_CNT_EN
    chk("discard_cnt_o", g, 64'(dcnt_v[g]), 64'(mdisc[g]));
`endif

    hs     = e_req && aok_v[g];
    malloc = mis && !full && !mdone[g];
    if (hs) begin
      if (hs_tot[g] < 4) hs_addr[g][hs_tot[g]] = mpc[g];
      hs_tot[g]++;
    end
    if (e_ov && rdy_v[g]) begin
      if (dl_tot[g] == 0) first_dpc[g] = mq[g][0].pc;
      dl_tot[g]++;
      if (mq[g][0].adel) adel_tot[g]++;
      last_dpc[g]   = mq[g][0].pc;
      last_dinst[g] = mq[g][0].inst;
      last_dadel[g] = mq[g][0].adel;
    end

    pop      = (mq[g].size() > 0) && mq[g][0].filled && (mq[g][0].kill || (e_ov && rdy_v[g]));
    pop_kill = pop && mq[g][0].kill;

    if (dok_v[g]) begin
      found = 1'b0;
      for (int i = 0; i < mq[g].size(); i++) begin
        if (!found && !mq[g][i].filled) begin
          e = mq[g][i]; e.filled = 1'b1; e.inst = rdata_v[g] & imask(g); mq[g][i] = e;
          found = 1'b1;
        end
      end
    end
    if (redir) begin
      for (int i = 0; i < mq[g].size(); i++) begin
        e = mq[g][i]; e.kill = 1'b1; mq[g][i] = e;
      end
    end
    if (pop) begin
      if (pop_kill) mdisc[g] = mdisc[g] + 32'd1;
      void'(mq[g].pop_front());
    end
    if (hs || malloc) begin
      e.pc = mpc[g]; e.inst = 64'h0; e.filled = malloc; e.adel = malloc; e.kill = redir;
      mq[g].push_back(e);
    end

    if (redir) mpc[g] = tgt;
    else if (hs) mpc[g] = mpc[g] + fb(g);
    if (redir) mdone[g] = 1'b0;
    else if (malloc) mdone[g] = 1'b1;
  endtask

  // ---------------- compare process ----------------
  initial begin : compare
    for (int g = 0; g < 2; g++) begin
      model_reset(g);
      hs_tot[g] = 0; dl_tot[g] = 0; adel_tot[g] = 0;
    end
    forever begin
      @(negedge clk);
      #1;
      case (pin)
        1: for (int g = 0; g < 2; g++) begin
             chk("pin_reset_vector", g, 64'(pc_v[g]), 64'(32'hbfc0_0000));
             chk("pin_first_req", g, 64'(req_v[g]), 64'(1'b1));
           end
        2: begin
             chk("pin_addr0", 0, 64'(hs_addr[0][0]), 64'(32'hbfc0_0000));
             chk("pin_addr1", 0, 64'(hs_addr[0][1]), 64'(32'hbfc0_0004));
             chk("pin_addr2", 0, 64'(hs_addr[0][2]), 64'(32'hbfc0_0008));
             chk("pin_addr0", 1, 64'(hs_addr[1][0]), 64'(32'hbfc0_0000));
             chk("pin_addr1", 1, 64'(hs_addr[1][1]), 64'(32'hbfc0_0008));
             chk("pin_addr2", 1, 64'(hs_addr[1][2]), 64'(32'hbfc0_0010));
             for (int g = 0; g < 2; g++) chk("pin_first_out_pc", g, 64'(first_dpc[g]), 64'(32'hbfc0_0000));
           end
        10: for (int g = 0; g < 2; g++) chk("pin_drain_bound", g, 64'(mq[g].size()), 64'd0);
        30: for (int g = 0; g < 2; g++) begin hs_snap[g] = hs_tot[g]; pc_snap[g] = pc_v[g]; end
        3: begin
             chk("pin_inflight", 0, 64'(hs_tot[0] - hs_snap[0]), 64'd2);
             chk("pin_inflight", 1, 64'(hs_tot[1] - hs_snap[1]), 64'd4);
             chk("pin_pc_advance", 0, 64'(pc_v[0] - pc_snap[0]), 64'd8);
             chk("pin_pc_advance", 1, 64'(pc_v[1] - pc_snap[1]), 64'd32);
             for (int g = 0; g < 2; g++) chk("pin_full_req", g, 64'(req_v[g]), 64'd0);
           end
        40: for (int g = 0; g < 2; g++) begin
              dl_snap[g] = dl_tot[g]; disc_snap[g] = mdisc[g]; dcnt_snap[g] = dcnt_v[g];
            end
        4: begin
             for (int g = 0; g < 2; g++) begin
               chk("pin_no_stale_delivery", g, 64'(dl_tot[g] - dl_snap[g]), 64'd0);
               chk("pin_branch_pc", g, 64'(addr_v[g]), 64'(32'h8000_1000));
               chk("pin_branch_req", g, 64'(req_v[g]), 64'd1);
             end
             chk("pin_discards", 0, 64'(mdisc[0] - disc_snap[0]), 64'd2);
             chk("pin_discards", 1, 64'(mdisc[1] - disc_snap[1]), 64'd4);
`ifdef FETCH_DISCARD_CNT_EN
             chk("pin_discard_cnt_o", 0, 64'(dcnt_v[0] - dcnt_snap[0]), 64'd2);
             chk("pin_discard_cnt_o", 1, 64'(dcnt_v[1] - dcnt_snap[1]), 64'd4);
`endif
           end
        6: for (int g = 0; g < 2; g++) chk("pin_exc_priority", g, 64'(pc_v[g]), 64'(32'hbfc0_0380));
        50: for (int g = 0; g < 2; g++) begin dl_snap[g] = dl_tot[g]; adel_snap[g] = adel_tot[g]; end
        7: for (int g = 0; g < 2; g++) begin
             chk("pin_adel_count", g, 64'(adel_tot[g] - adel_snap[g]), 64'd1);
             chk("pin_adel_deliveries", g, 64'(dl_tot[g] - dl_snap[g]), 64'd1);
             chk("pin_adel_pc", g, 64'(last_dpc[g]), 64'(32'h8000_0002));
             chk("pin_adel_inst", g, last_dinst[g], 64'd0);
             chk("pin_adel_flag", g, 64'(last_dadel[g]), 64'd1);
             chk("pin_adel_no_req", g, 64'(req_v[g]), 64'd0);
           end
        80: for (int g = 0; g < 2; g++) chk("pin_head_ready", g, 64'(ov_v[g]), 64'd1);
        8: for (int g = 0; g < 2; g++) begin
             chk("pin_rst_pc", g, 64'(pc_v[g]), 64'(32'hbfc0_0000));
             chk("pin_rst_valid", g, 64'(ov_v[g]), 64'd0);
             chk("pin_rst_req", g, 64'(req_v[g]), 64'd0);
             chk("pin_rst_out_pc", g, 64'(opc_v[g]), 64'd0);
             chk("pin_rst_out_inst", g, oinst_v[g], 64'd0);
             chk("pin_rst_out_adel", g, 64'(oadel_v[g]), 64'd0);
           end
        9: for (int g = 0; g < 2; g++) begin
             chk("pin_late_data_ok", g, 64'(ov_v[g]), 64'd0);
             chk("pin_late_pc", g, 64'(pc_v[g]), 64'(32'hbfc0_0000));
           end
        default: ;
      endcase
      for (int g = 0; g < 2; g++) begin
        if (!rst) begin
          model_reset(g);
          chk("rst_pc_o", g, 64'(pc_v[g]), 64'(mpc[g]));
          chk("rst_inst_req_o", g, 64'(req_v[g]), 64'd0);
          chk("rst_out_valid_o", g, 64'(ov_v[g]), 64'd0);
          chk("rst_out_pc_o", g, 64'(opc_v[g]), 64'd0);
          chk("rst_out_inst_o", g, oinst_v[g], 64'd0);
          chk("rst_out_adel_o", g, 64'(oadel_v[g]), 64'd0);
`ifdef FETCH_DISCARD_CNT_EN
          chk("rst_discard_cnt_o", g, 64'(dcnt_v[g]), 64'd0);
`endif
        end else begin
          model_step(g);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clk);
    pin = 0;
    for (int g = 0; g < 2; g++) begin
      exc_v[g] = 1'b0; exc_pc_v[g] = 32'h0; br_v[g] = 1'b0; br_addr_v[g] = 32'h0;
      aok_v[g] = 1'b0; dok_v[g] = 1'b0; rdata_v[g] = 64'h0; rdy_v[g] = 1'b1;
    end
  endtask

  task automatic drive_dok(input int g, input int unsigned pct);
    dok_v[g]   = has_unf(g) && ($urandom_range(0, 99) < pct);
    rdata_v[g] = {$urandom(), $urandom()};
  endtask

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    t = $urandom();
    if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  task automatic branch_all(input logic [31:0] a);
    for (int g = 0; g < 2; g++) begin br_v[g] = 1'b1; br_addr_v[g] = a; end
  endtask

  task automatic drain(input int p);
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (i == 0) pin = p;
      for (int g = 0; g < 2; g++) drive_dok(g, 100);
      if (mq[0].size() == 0 && mq[1].size() == 0) break;
    end
    cyc();
    pin = 10;
  endtask

  initial begin : stimulus
    pin = 0;
    for (int g = 0; g < 2; g++) begin
      exc_v[g] = 1'b0; exc_pc_v[g] = 32'h0; br_v[g] = 1'b0; br_addr_v[g] = 32'h0;
      aok_v[g] = 1'b0; dok_v[g] = 1'b0; rdata_v[g] = 64'h0; rdy_v[g] = 1'b1;
    end
    rst = 1'b0;
    repeat (3) cyc();

    // sequential stream with one-cycle data return
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (i == 0) begin rst = 1'b1; pin = 1; end
      for (int g = 0; g < 2; g++) begin aok_v[g] = 1'b1; drive_dok(g, 100); end
    end
    drain(2);

    // no data returns: queue fills and requests stop
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (i == 0) pin = 30;
      for (int g = 0; g < 2; g++) aok_v[g] = 1'b1;
    end
    cyc(); pin = 3;

    // branch with everything in flight
    cyc(); pin = 40; branch_all(32'h8000_1000);
    for (int i = 0; i < 8; i++) begin
      cyc();
      for (int g = 0; g < 2; g++) drive_dok(g, 100);
    end
    cyc(); pin = 4;

    // exception outranks a same-cycle branch
    cyc();
    branch_all(32'h8000_4000);
    for (int g = 0; g < 2; g++) begin exc_v[g] = 1'b1; exc_pc_v[g] = 32'hbfc0_0380; end
    cyc(); pin = 6;

    // misaligned target
    cyc(); pin = 50; branch_all(32'h8000_0002);
    for (int i = 0; i < 6; i++) begin
      cyc();
      for (int g = 0; g < 2; g++) begin aok_v[g] = 1'b1; drive_dok(g, 100); end
    end
    cyc(); pin = 7;
    cyc(); branch_all(32'h8000_2000);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      cyc();
      for (int g = 0; g < 2; g++) begin
        exc_v[g]     = $urandom_range(0, 99) < 2;
        exc_pc_v[g]  = rand_tgt();
        br_v[g]      = $urandom_range(0, 99) < 6;
        br_addr_v[g] = rand_tgt();
        aok_v[g]     = $urandom_range(0, 99) < 60;
        rdy_v[g]     = $urandom_range(0, 99) < 70;
        drive_dok(g, 50);
      end
    end

    // reset while a filled head waits on a stalled decode
    cyc(); branch_all(32'h8000_2000);
    drain(0);
    cyc();
    for (int g = 0; g < 2; g++) begin aok_v[g] = 1'b1; rdy_v[g] = 1'b0; end
    for (int i = 0; i < 2; i++) begin
      cyc();
      if (i == 1) pin = 80;
      for (int g = 0; g < 2; g++) begin rdy_v[g] = 1'b0; drive_dok(g, 100); end
    end
    cyc(); rst = 1'b0; pin = 8;
    for (int g = 0; g < 2; g++) rdy_v[g] = 1'b0;
    cyc();
    cyc(); rst = 1'b1;
    for (int g = 0; g < 2; g++) begin dok_v[g] = 1'b1; rdata_v[g] = 64'hdead_beef_cafe_f00d; end
    cyc(); pin = 9;
    repeat (3) cyc();

    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
